// File: rtl/clk_phase_checker.sv
// rtl/clk_phase_checker.sv - ring-oscillator phase-count checker with per-channel fault voting
// Optional status counters (evt_count, last_fault_ch) enabled by CLK_PHASE_CHECKER_STATUS_EN.
module clk_phase_checker #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 4,
  parameter int TOL         = 2,
  parameter int MISS_LIMIT  = 2,
  parameter int VOTE_MIN    = 2,
  parameter int CAL_SAMPLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         en,
  input  logic                      meas_valid,
  input  logic                      meas_phase,
  input  logic [NUM_CH*CNT_W-1:0]   meas_cnt,
  input  logic                      clear_alarm,
  output logic                      alarm,
  output logic                      alarm_sticky,
  output logic                      calibrating,
  output logic [NUM_CH-1:0]         mismatch,
  output logic [NUM_CH-1:0]         ch_fault,
  output logic [15:0]               evt_count,
  output logic [$clog2(NUM_CH)-1:0] last_fault_ch
);

  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam int CAL_W  = $clog2(CAL_SAMPLES + 1);
  localparam int LFC_W  = $clog2(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_CAL, S_RUN, S_ALARM} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_ref [NUM_CH][2];
  logic [MISS_W-1:0]   r_miss [NUM_CH];
  logic [NUM_CH-1:0]   r_mm;
  logic [CAL_W-1:0]    r_cal_cnt;
  logic [NUM_CH-1:0]   r_en_prev;
  logic                r_alarm;
  logic [NUM_CH-1:0]   w_fault;
  logic [NUM_CH-1:0]   w_mm_new;

  // Differences are taken one bit wider so a count far from its reference never wraps to a small value.
  always_comb begin
    logic [CNT_W:0] w_a, w_b, w_diff;
    w_fault  = '0;
    w_mm_new = '0;
    w_a      = '0;
    w_b      = '0;
    w_diff   = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_fault[ch]  = en[ch] && (r_miss[ch] == MISS_W'(MISS_LIMIT));
      w_a          = {1'b0, meas_cnt[ch*CNT_W +: CNT_W]};
      w_b          = {1'b0, r_ref[ch][meas_phase]};
      w_diff       = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
      w_mm_new[ch] = en[ch] && (w_diff > (CNT_W+1)'(TOL));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_state != S_ALARM && en == '0) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_CAL;
        S_CAL:   if (meas_valid && r_cal_cnt == CAL_W'(CAL_SAMPLES - 1)) w_next = S_RUN;
        S_RUN: begin
          if (en != r_en_prev)                       w_next = S_CAL;
          else if ($countones(w_fault) >= VOTE_MIN)  w_next = S_ALARM;
        end
        S_ALARM: if (clear_alarm) w_next = (en == '0) ? S_IDLE : S_CAL;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mm      <= '0;
      r_cal_cnt <= '0;
      r_en_prev <= '0;
      r_alarm   <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_miss[ch]   <= '0;
        r_ref[ch][0] <= '0;
        r_ref[ch][1] <= '0;
      end
    end else begin
      r_en_prev <= en;
      r_alarm   <= (r_state != S_ALARM) && (w_next == S_ALARM);
      case (r_state)
        S_CAL: begin
          r_mm <= '0;
          for (int ch = 0; ch < NUM_CH; ch++) r_miss[ch] <= '0;
          if (meas_valid) begin
            r_cal_cnt <= r_cal_cnt + CAL_W'(1);
            for (int ch = 0; ch < NUM_CH; ch++)
              r_ref[ch][meas_phase] <= meas_cnt[ch*CNT_W +: CNT_W];
          end
        end
        S_RUN: begin
          r_cal_cnt <= '0;
          if (meas_valid) begin
            r_mm <= w_mm_new;
            for (int ch = 0; ch < NUM_CH; ch++) begin
              if (!en[ch]) begin
                r_miss[ch] <= '0;
              end else if (w_mm_new[ch]) begin
                if (r_miss[ch] != MISS_W'(MISS_LIMIT)) r_miss[ch] <= r_miss[ch] + MISS_W'(1);
              end else begin
                r_miss[ch]            <= '0;
                r_ref[ch][meas_phase] <= meas_cnt[ch*CNT_W +: CNT_W];
              end
            end
          end
        end
        S_ALARM: begin
          if (clear_alarm) begin
            r_mm      <= '0;
            r_cal_cnt <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) r_miss[ch] <= '0;
          end
        end
        default: begin
          r_mm      <= '0;
          r_cal_cnt <= '0;
          for (int ch = 0; ch < NUM_CH; ch++) r_miss[ch] <= '0;
        end
      endcase
    end
  end

  always_comb begin
    calibrating  = (r_state == S_CAL);
    alarm_sticky = (r_state == S_ALARM);
    alarm        = r_alarm;
    mismatch     = r_mm & en;
    ch_fault     = w_fault;
  end

`ifdef CLK_PHASE_CHECKER_STATUS_EN
  logic [15:0]      r_evt;
  logic [LFC_W-1:0] r_lfc;
  logic [LFC_W-1:0] w_low;

  always_comb begin
    w_low = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_fault[i]) w_low = LFC_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt <= '0;
      r_lfc <= '0;
    end else begin
      if (r_state == S_RUN && meas_valid && (|w_mm_new) && r_evt != 16'hFFFF)
        r_evt <= r_evt + 16'd1;
      if (r_state != S_ALARM && w_next == S_ALARM)
        r_lfc <= w_low;
    end
  end

  assign evt_count     = r_evt;
  assign last_fault_ch = r_lfc;
`else
  assign evt_count     = '0;
  assign last_fault_ch = '0;
`endif

endmodule

// File: tb/tb_clk_phase_checker.sv
// tb/tb_clk_phase_checker.sv - vector table, status sequence and randomized model check for clk_phase_checker
module tb_clk_phase_checker;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam int TOL    = 2;
  localparam int ML     = 2;
  localparam int VM     = 2;
  localparam int CS     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        meas_valid, meas_phase, clear_alarm;
  logic [15:0] meas_cnt;
  logic        alarm, alarm_sticky, calibrating;
  logic [3:0]  mismatch, ch_fault;
  logic [15:0] evt_count;
  logic [1:0]  last_fault_ch;

  clk_phase_checker #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TOL(TOL), .MISS_LIMIT(ML), .VOTE_MIN(VM), .CAL_SAMPLES(CS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .meas_valid(meas_valid), .meas_phase(meas_phase),
    .meas_cnt(meas_cnt), .clear_alarm(clear_alarm), .alarm(alarm), .alarm_sticky(alarm_sticky),
    .calibrating(calibrating), .mismatch(mismatch), .ch_fault(ch_fault),
    .evt_count(evt_count), .last_fault_ch(last_fault_ch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pk(input logic [3:0] c3, input logic [3:0] c2,
                                     input logic [3:0] c1, input logic [3:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  typedef struct {
    logic [3:0]  en;
    logic        v;
    logic        ph;
    logic [15:0] cnt;
    logic        clr;
    logic        cal;
    logic [3:0]  mm;
    logic [3:0]  flt;
    logic        al;
    logic        st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] e, input logic v, input logic ph, input logic [15:0] c,
                              input logic clr, input logic cal, input logic [3:0] mm,
                              input logic [3:0] flt, input logic al, input logic st);
    vec_t r;
    r.en = e; r.v = v; r.ph = ph; r.cnt = c; r.clr = clr;
    r.cal = cal; r.mm = mm; r.flt = flt; r.al = al; r.st = st;
    return r;
  endfunction

  // Reference model: spec-level state of the checker, advanced once per clock edge.
  int         m_mode;
  int         m_ref[4][2];
  int         m_miss[4];
  bit [3:0]   m_mm;
  int         m_cal;
  bit [3:0]   m_enp;
  bit         m_alarm;
  int         m_evt;
  int         m_lfc;

  task automatic model_reset;
    m_mode = 0; m_mm = '0; m_cal = 0; m_enp = '0; m_alarm = 0; m_evt = 0; m_lfc = 0;
    for (int c = 0; c < 4; c++) begin
      m_miss[c] = 0; m_ref[c][0] = 0; m_ref[c][1] = 0;
    end
  endtask

  task automatic model_step;
    bit [3:0] flt;
    bit [3:0] newmm;
    int votes, nxt, c, d, low;
    votes = 0;
    low = -1;
    for (int k = 0; k < 4; k++) begin
      flt[k] = en[k] && (m_miss[k] == ML);
      votes += int'(flt[k]);
      if (flt[k] && low < 0) low = k;
      c = int'(meas_cnt[k*4 +: 4]);
      d = c - m_ref[k][meas_phase];
      if (d < 0) d = -d;
      newmm[k] = en[k] && (d > TOL);
    end
    nxt = m_mode;
    if (m_mode != 3 && en == 4'd0) nxt = 0;
    else if (m_mode == 0) nxt = 1;
    else if (m_mode == 1) begin
      if (meas_valid && m_cal + 1 == CS) nxt = 2;
    end else if (m_mode == 2) begin
      if (en != m_enp) nxt = 1;
      else if (votes >= VM) nxt = 3;
    end else if (clear_alarm) nxt = (en == 4'd0) ? 0 : 1;
    m_alarm = (m_mode != 3) && (nxt == 3);
`ifdef CLK_PHASE_CHECKER_STATUS_EN
    if (m_mode == 2 && meas_valid && newmm != 0 && m_evt < 65535) m_evt++;
    if (m_alarm) m_lfc = (low < 0) ? 0 : low;
`endif
    if (m_mode == 1) begin
      m_mm = '0;
      for (int k = 0; k < 4; k++) m_miss[k] = 0;
      if (meas_valid) begin
        m_cal++;
        for (int k = 0; k < 4; k++) m_ref[k][meas_phase] = int'(meas_cnt[k*4 +: 4]);
      end
    end else if (m_mode == 2) begin
      m_cal = 0;
      if (meas_valid) begin
        m_mm = newmm;
        for (int k = 0; k < 4; k++) begin
          if (!en[k]) m_miss[k] = 0;
          else if (newmm[k]) m_miss[k] = (m_miss[k] + 1 > ML) ? ML : m_miss[k] + 1;
          else begin
            m_miss[k] = 0;
            m_ref[k][meas_phase] = int'(meas_cnt[k*4 +: 4]);
          end
        end
      end
    end else if (m_mode == 3) begin
      if (clear_alarm) begin
        m_mm = '0; m_cal = 0;
        for (int k = 0; k < 4; k++) m_miss[k] = 0;
      end
    end else begin
      m_mm = '0; m_cal = 0;
      for (int k = 0; k < 4; k++) m_miss[k] = 0;
    end
    m_enp = en;
    m_mode = nxt;
  endtask

  task automatic model_compare(input string tag);
    bit [3:0] eflt;
    for (int k = 0; k < 4; k++) eflt[k] = en[k] && (m_miss[k] == ML);
    chk({tag, "_ctl"}, {alarm, alarm_sticky, calibrating, mismatch, ch_fault},
        {m_alarm, (m_mode == 3), (m_mode == 1), m_mm & en, eflt});
    chk({tag, "_status"}, {evt_count, 14'd0, last_fault_ch}, {m_evt[15:0], 14'd0, m_lfc[1:0]});
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_in(input logic [3:0] e, input logic v, input logic ph, input logic [15:0] c,
                        input logic clr);
    en = e; meas_valid = v; meas_phase = ph; meas_cnt = c; clear_alarm = clr;
  endtask

  int exp_evt3, exp_lfc1;

  initial begin
    rst = 1'b1;
    set_in(4'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    tick();
    chk("rst_alarm", alarm, 0);
    chk("rst_sticky", alarm_sticky, 0);
    chk("rst_cal", calibrating, 0);
    chk("rst_mm", mismatch, 0);
    chk("rst_fault", ch_fault, 0);
    chk("rst_evt", evt_count, 0);
    chk("rst_lfc", last_fault_ch, 0);
    rst = 1'b0;

    tbl.push_back(mk(4'hF, 0, 0, pk(8, 8, 8, 8),    0, 1, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 0, pk(8, 8, 8, 8),    0, 1, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 1, pk(8, 8, 8, 8),    0, 1, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 0, pk(8, 8, 8, 8),    0, 1, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 1, pk(8, 8, 8, 8),    0, 0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 0, pk(8, 8, 8, 11),   0, 0, 4'h1, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 0, 0, pk(8, 8, 8, 8),    0, 0, 4'h1, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 0, pk(8, 8, 8, 10),   0, 0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 0, pk(8, 8, 8, 13),   0, 0, 4'h1, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 0, pk(8, 8, 8, 13),   0, 0, 4'h1, 4'h1, 0, 0));
    tbl.push_back(mk(4'hF, 0, 0, pk(8, 8, 8, 8),    0, 0, 4'h1, 4'h1, 0, 0));
    tbl.push_back(mk(4'hF, 1, 0, pk(8, 8, 8, 10),   0, 0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 1, pk(8, 8, 4, 12),   0, 0, 4'h3, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 1, pk(8, 8, 4, 12),   0, 0, 4'h3, 4'h3, 0, 0));
    tbl.push_back(mk(4'hF, 0, 0, pk(8, 8, 8, 8),    0, 0, 4'h3, 4'h3, 1, 1));
    tbl.push_back(mk(4'hF, 0, 0, pk(8, 8, 8, 8),    0, 0, 4'h3, 4'h3, 0, 1));
    tbl.push_back(mk(4'hF, 1, 0, pk(0, 0, 0, 0),    0, 0, 4'h3, 4'h3, 0, 1));
    tbl.push_back(mk(4'hF, 1, 0, pk(15, 15, 15, 15), 1, 1, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 0, pk(8, 8, 8, 8),    0, 1, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 1, pk(8, 8, 8, 8),    0, 1, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 0, pk(8, 8, 8, 8),    0, 1, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 1, pk(8, 8, 8, 8),    0, 0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 0, pk(8, 8, 8, 8),    0, 0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'h3, 0, 0, pk(8, 8, 8, 8),    0, 1, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 0, pk(8, 8, 8, 8),    0, 0, 4'h0, 4'h0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].en, tbl[i].v, tbl[i].ph, tbl[i].cnt, tbl[i].clr);
      tick();
      chk($sformatf("vec%0d_cal", i), calibrating, tbl[i].cal);
      chk($sformatf("vec%0d_mm", i), mismatch, tbl[i].mm);
      chk($sformatf("vec%0d_fault", i), ch_fault, tbl[i].flt);
      chk($sformatf("vec%0d_alarm", i), alarm, tbl[i].al);
      chk($sformatf("vec%0d_sticky", i), alarm_sticky, tbl[i].st);
    end

`ifdef CLK_PHASE_CHECKER_STATUS_EN
    exp_evt3 = 3; exp_lfc1 = 1;
`else
    exp_evt3 = 0; exp_lfc1 = 0;
`endif
    set_in(4'h0, 0, 0, pk(8, 8, 8, 8), 0);
    do_reset();
    set_in(4'hF, 0, 0, pk(8, 8, 8, 8), 0);
    tick();
    for (int i = 0; i < CS; i++) begin
      set_in(4'hF, 1, i[0], pk(8, 8, 8, 8), 0);
      tick();
    end
    set_in(4'hF, 1, 0, pk(8, 8, 8, 12), 0);
    tick();
    chk("st_evt1", evt_count, 32'(exp_evt3 / 3));
    set_in(4'hF, 1, 0, pk(8, 12, 12, 8), 0);
    tick();
    tick();
    chk("st_fault", ch_fault, 4'h6);
    set_in(4'hF, 0, 0, pk(8, 8, 8, 8), 0);
    tick();
    chk("st_alarm", alarm, 1);
    chk("st_evt3", evt_count, 32'(exp_evt3));
    chk("st_lfc", last_fault_ch, 32'(exp_lfc1));

    #2 rst = 1'b1;
    #1;
    chk("midrst_sticky", alarm_sticky, 0);
    chk("midrst_alarm", alarm, 0);
    chk("midrst_fault", ch_fault, 0);
    chk("midrst_evt", evt_count, 0);
    chk("midrst_lfc", last_fault_ch, 0);
    rst = 1'b0;
    tick();
    chk("postrst_alarm", alarm, 0);
    chk("postrst_cal", calibrating, 1);

    set_in(4'hF, 0, 0, pk(8, 8, 8, 8), 0);
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 63) == 0) en = 4'($urandom_range(0, 15));
      meas_valid  = 1'($urandom_range(0, 1));
      meas_phase  = 1'($urandom_range(0, 1));
      clear_alarm = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 4; k++)
        meas_cnt[k*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                         : 4'($urandom_range(4, 12));
      model_step();
      tick();
      model_compare($sformatf("rand%0d", n));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        model_compare($sformatf("rand%0d_rst", n));
        #1 rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
